// File: rtl/neighbor_address_generator.sv
// Aggregation-phase sequencer: walks NIT rows, issuing each row's centroid and then
// its 32 neighbors as conflict-free per-bank PFT reads, with framing flags for the max datapath.
module neighbor_address_generator #(
  parameter int input_width     = 330,
  parameter int bank            = 32,
  parameter int microaddr_width = 5,
  parameter int NIT_addr_width  = 12,
  parameter int NIT_point_index = 10,
  parameter int PE_COL          = 16
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [input_width-1:0]            neighbor_input,
  input  logic                              start,
  input  logic [12:0]                       N_SAMPLE,
  output logic [bank-1:0]                   valid,
  output logic [bank*microaddr_width-1:0]   PFT_addr,
  output logic                              is_centroid,
  output logic                              is_neighbor,
  output logic [NIT_addr_width-1:0]         NIT_addr,
  output logic                              NIT_done,
  output logic [1:0]                        repetition
);

  localparam int NNBR   = input_width / NIT_point_index - 1;
  localparam int BANK_W = $clog2(bank);
  localparam int ROW_W  = 13;
  localparam int MW     = microaddr_width;

  if (NIT_point_index != BANK_W + MW || input_width % NIT_point_index != 0 || PE_COL < 1) begin : g_param_check
    $error("neighbor_address_generator: inconsistent parameters");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_CAPTURE, S_CENTROID, S_NEIGHBOR, S_DONE
  } state_t;

  state_t                          r_state;
  state_t                          w_state_next;
  logic [ROW_W-1:0]                r_n_sample;
  logic [ROW_W-1:0]                r_row;
  logic [NNBR*NIT_point_index-1:0] r_nbr_data;
  logic [NNBR-1:0]                 r_pending;

  logic [bank-1:0]                 r_valid;
  logic [bank*MW-1:0]              r_pft_addr;
  logic                            r_is_centroid;
  logic                            r_is_neighbor;
  logic [NIT_addr_width-1:0]       r_nit_addr;
  logic                            r_nit_done;
  logic [1:0]                      r_repetition;

  logic [NIT_point_index-1:0]      w_nbr [NNBR];
  logic [NNBR-1:0]                 w_match [bank];
  logic [NNBR-1:0]                 w_pick [bank];
  logic [bank-1:0]                 w_bank_hit;
  logic [MW-1:0]                   w_pick_addr [bank];
  logic [NNBR-1:0]                 w_granted;
  logic [NNBR-1:0]                 w_pending_left;
  logic                            w_rows_left;
  logic [ROW_W-1:0]                w_row_load;
  logic [ROW_W:0]                  w_prefetch_row;
  logic [BANK_W-1:0]               w_cent_bank;
  logic [MW-1:0]                   w_cent_micro;

  logic [bank-1:0]                 w_valid_next;
  logic [bank*MW-1:0]              w_pft_next;
  logic                            w_cent_next;
  logic                            w_nbr_next;
  logic [NIT_addr_width-1:0]       w_nit_addr_next;
  logic                            w_done_next;
  logic [1:0]                      w_rep_next;

  genvar gi, gj;

  for (gi = 0; gi < NNBR; gi++) begin : g_nbr
    assign w_nbr[gi] = r_nbr_data[gi*NIT_point_index +: NIT_point_index];
  end

  // Per bank: isolate the lowest-numbered pending neighbor that maps to it.
  for (gi = 0; gi < bank; gi++) begin : g_bank
    for (gj = 0; gj < NNBR; gj++) begin : g_match
      assign w_match[gi][gj] = r_pending[gj] && (w_nbr[gj][BANK_W-1:0] == BANK_W'(gi));
    end
    assign w_pick[gi]     = w_match[gi] & (~w_match[gi] + NNBR'(1));
    assign w_bank_hit[gi] = |w_match[gi];
  end

  always_comb begin
    w_granted = '0;
    for (int b = 0; b < bank; b++) begin
      w_pick_addr[b] = '0;
      for (int k = 0; k < NNBR; k++) begin
        if (w_pick[b][k]) begin
          w_pick_addr[b] = w_pick_addr[b] | w_nbr[k][NIT_point_index-1 -: MW];
        end
      end
      w_granted = w_granted | w_pick[b];
    end
  end

  assign w_pending_left = r_pending & ~w_granted;
  assign w_rows_left    = ({1'b0, r_row} + (ROW_W+1)'(1)) < {1'b0, r_n_sample};
  assign w_row_load     = (r_state == S_CAPTURE) ? '0 : r_row + ROW_W'(1);
  assign w_prefetch_row = {1'b0, w_row_load} + (ROW_W+1)'(1);
  assign w_cent_bank    = neighbor_input[BANK_W-1:0];
  assign w_cent_micro   = neighbor_input[NIT_point_index-1 -: MW];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // r_pending holds what is left after the pass currently on the outputs.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:     if (start) w_state_next = (N_SAMPLE == '0) ? S_DONE : S_FETCH;
      S_FETCH:    w_state_next = S_CAPTURE;
      S_CAPTURE:  w_state_next = S_CENTROID;
      S_CENTROID: w_state_next = S_NEIGHBOR;
      S_NEIGHBOR: if (r_pending == '0) w_state_next = w_rows_left ? S_CENTROID : S_DONE;
      S_DONE:     w_state_next = S_IDLE;
      default:    w_state_next = S_IDLE;
    endcase
  end

  // Outputs are loaded together with the state they belong to, so they line up with it.
  always_comb begin
    w_valid_next    = '0;
    w_pft_next      = '0;
    w_cent_next     = 1'b0;
    w_nbr_next      = 1'b0;
    w_rep_next      = 2'b00;
    w_done_next     = (w_state_next == S_DONE);
    w_nit_addr_next = r_nit_addr;
    if (r_state == S_IDLE && start) begin
      w_nit_addr_next = '0;
    end
    if (w_state_next == S_CENTROID) begin
      w_cent_next = 1'b1;
      for (int b = 0; b < bank; b++) begin
        if (BANK_W'(b) == w_cent_bank) begin
          w_valid_next[b]        = 1'b1;
          w_pft_next[b*MW +: MW] = w_cent_micro;
        end
      end
      if (w_prefetch_row < {1'b0, r_n_sample}) begin
        w_nit_addr_next = w_prefetch_row[NIT_addr_width-1:0];
      end
    end
    if (w_state_next == S_NEIGHBOR) begin
      w_valid_next = w_bank_hit;
      for (int b = 0; b < bank; b++) begin
        w_pft_next[b*MW +: MW] = w_pick_addr[b];
      end
      w_rep_next = (r_state == S_CENTROID) ? 2'b01 : 2'b10;
      w_nbr_next = (w_pending_left == '0);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid       <= '0;
      r_pft_addr    <= '0;
      r_is_centroid <= 1'b0;
      r_is_neighbor <= 1'b0;
      r_nit_addr    <= '0;
      r_nit_done    <= 1'b0;
      r_repetition  <= 2'b00;
      r_n_sample    <= '0;
      r_row         <= '0;
      r_nbr_data    <= '0;
      r_pending     <= '0;
    end else begin
      r_valid       <= w_valid_next;
      r_pft_addr    <= w_pft_next;
      r_is_centroid <= w_cent_next;
      r_is_neighbor <= w_nbr_next;
      r_nit_addr    <= w_nit_addr_next;
      r_nit_done    <= w_done_next;
      r_repetition  <= w_rep_next;
      if (r_state == S_IDLE && start) begin
        r_n_sample <= N_SAMPLE;
      end
      if (w_state_next == S_CENTROID) begin
        r_nbr_data <= neighbor_input[input_width-1:NIT_point_index];
        r_pending  <= '1;
        r_row      <= w_row_load;
      end else if (w_state_next == S_NEIGHBOR) begin
        r_pending  <= w_pending_left;
      end
    end
  end

  assign valid       = r_valid;
  assign PFT_addr    = r_pft_addr;
  assign is_centroid = r_is_centroid;
  assign is_neighbor = r_is_neighbor;
  assign NIT_addr    = r_nit_addr;
  assign NIT_done    = r_nit_done;
  assign repetition  = r_repetition;

endmodule

// File: tb/tb_neighbor_address_generator.sv
// Randomised bench for neighbor_address_generator: an NIT memory model feeds rows and
// a per-cycle expectation list built from bank-occupancy ranks is compared every cycle.
module tb_neighbor_address_generator;
  localparam int IW = 330;
  localparam int NB = 32;
  localparam int MW = 5;
  localparam int AW = 12;
  localparam int PW = 10;
  localparam int CW = NB*MW;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          start = 1'b0;
  logic [IW-1:0] neighbor_input = '0;
  logic [12:0]   n_sample = '0;
  logic [NB-1:0] valid;
  logic [CW-1:0] PFT_addr;
  logic          is_centroid;
  logic          is_neighbor;
  logic [AW-1:0] NIT_addr;
  logic          NIT_done;
  logic [1:0]    repetition;

  always #5 clk = ~clk;

  neighbor_address_generator dut (
    .clk(clk), .rstn(rstn), .neighbor_input(neighbor_input), .start(start),
    .N_SAMPLE(n_sample), .valid(valid), .PFT_addr(PFT_addr), .is_centroid(is_centroid),
    .is_neighbor(is_neighbor), .NIT_addr(NIT_addr), .NIT_done(NIT_done), .repetition(repetition)
  );

  // NIT memory with one cycle of read latency
  logic [IW-1:0] nit_mem [16];
  always @(posedge clk) neighbor_input <= nit_mem[NIT_addr[3:0]];

  typedef struct {
    logic [NB-1:0] valid;
    logic [CW-1:0] pft;
    logic [4:0]    flags;   // {is_centroid, is_neighbor, repetition, NIT_done}
    logic [AW-1:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  task automatic check_value(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_nbr(input int r, input int k, input int v);
    nit_mem[r][PW*(k+1) +: PW] = PW'(v);
  endtask

  // Pass p of a row issues, for every bank, the p-th neighbor (in k order) landing in that bank.
  task automatic build_expected(input int n);
    exp_t          e;
    logic [IW-1:0] row;
    int            bank_q[NB][$];
    int            cent, v, passes, addr;
    exp_q.delete();
    e = '{valid: '0, pft: '0, flags: '0, addr: '0};
    if (n == 0) begin
      e.flags = 5'b00001;
      exp_q.push_back(e);
      e.flags = 5'b00000;
      exp_q.push_back(e);
      return;
    end
    exp_q.push_back(e);
    exp_q.push_back(e);
    addr = 0;
    for (int r = 0; r < n; r++) begin
      row  = nit_mem[r];
      cent = int'(row[PW-1:0]);
      for (int b = 0; b < NB; b++) bank_q[b].delete();
      for (int k = 0; k < 32; k++) begin
        v = int'(row[PW*(k+1) +: PW]);
        bank_q[v % NB].push_back(v / NB);
      end
      addr = (r + 1 < n) ? r + 1 : r;
      e = '{valid: '0, pft: '0, flags: 5'b10000, addr: AW'(addr)};
      e.valid[cent % NB] = 1'b1;
      e.pft[(cent % NB)*MW +: MW] = MW'(cent / NB);
      exp_q.push_back(e);
      passes = 0;
      for (int b = 0; b < NB; b++) if (bank_q[b].size() > passes) passes = bank_q[b].size();
      for (int p = 0; p < passes; p++) begin
        e = '{valid: '0, pft: '0, flags: '0, addr: AW'(addr)};
        for (int b = 0; b < NB; b++) begin
          if (bank_q[b].size() > p) begin
            e.valid[b] = 1'b1;
            e.pft[b*MW +: MW] = MW'(bank_q[b][p]);
          end
        end
        e.flags = {1'b0, (p == passes - 1), (p == 0) ? 2'b01 : 2'b10, 1'b0};
        exp_q.push_back(e);
      end
    end
    e = '{valid: '0, pft: '0, flags: 5'b00001, addr: AW'(addr)};
    exp_q.push_back(e);
    e.flags = 5'b00000;
    exp_q.push_back(e);
  endtask

  // restart_cyc: cycle in which a stray start is raised; abort_cyc: cycle after which rstn drops.
  task automatic run_case(input int n, input int restart_cyc, input int abort_cyc, input string name);
    int done_seen = 0;
    int done_exp = 0;
    build_expected(n);
    foreach (exp_q[i]) done_exp += int'(exp_q[i].flags[0]);
    @(negedge clk);
    n_sample = 13'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < exp_q.size(); c++) begin
      check_value($sformatf("%s c%0d valid", name, c+1), CW'(valid), CW'(exp_q[c].valid));
      check_value($sformatf("%s c%0d pft_addr", name, c+1), PFT_addr, exp_q[c].pft);
      check_value($sformatf("%s c%0d flags", name, c+1),
                  CW'({is_centroid, is_neighbor, repetition, NIT_done}), CW'(exp_q[c].flags));
      check_value($sformatf("%s c%0d nit_addr", name, c+1), CW'(NIT_addr), CW'(exp_q[c].addr));
      $display("[TB] %s cycle %0d valid=%h cen=%0d nbr=%0d rep=%0d done=%0d addr=%0d",
               name, c+1, valid, is_centroid, is_neighbor, repetition, NIT_done, NIT_addr);
      done_seen += int'(NIT_done);
      if (c + 1 == abort_cyc) begin
        #2 rstn = 1'b0;
        #1;
        check_value({name, " async_reset pft"}, PFT_addr, '0);
        check_value({name, " async_reset ctrl"},
                    CW'({valid, is_centroid, is_neighbor, repetition, NIT_done, NIT_addr}), '0);
        @(negedge clk);
        rstn = 1'b1;
        return;
      end
      start = (c + 1 == restart_cyc);
      @(negedge clk);
    end
    start = 1'b0;
    check_value({name, " done_count"}, CW'(done_seen), CW'(done_exp));
  endtask

  task automatic fill_random(input int n, input int mode);
    int pool[3];
    for (int i = 0; i < 3; i++) pool[i] = int'($urandom_range(0, 1023));
    for (int r = 0; r < n; r++) begin
      nit_mem[r][PW-1:0] = PW'($urandom_range(0, 1023));
      for (int k = 0; k < 32; k++) begin
        case (mode)
          0:       set_nbr(r, k, int'($urandom_range(0, 1023)));
          1:       set_nbr(r, k, int'($urandom_range(0, 31)) * 32 + int'($urandom_range(0, 3)));
          default: set_nbr(r, k, pool[$urandom_range(0, 2)]);
        endcase
      end
    end
  endtask

  initial begin
    int sh;
    for (int i = 0; i < 16; i++) nit_mem[i] = '0;
    #1 rstn = 1'b0;
    repeat (3) @(negedge clk);
    check_value("reset pft", PFT_addr, '0);
    check_value("reset ctrl", CW'({valid, is_centroid, is_neighbor, repetition, NIT_done, NIT_addr}), '0);
    rstn = 1'b1;
    @(negedge clk);
    check_value("idle ctrl", CW'({valid, is_centroid, is_neighbor, repetition, NIT_done, NIT_addr}), '0);

    nit_mem[0][PW-1:0] = PW'(5);
    for (int k = 0; k < 32; k++) set_nbr(0, k, k + 32);
    run_case(1, 0, 0, "conflict_free");

    nit_mem[0][PW-1:0] = PW'($urandom_range(0, 1023));
    for (int k = 0; k < 32; k++) set_nbr(0, k, (64 * k) % 1024);
    run_case(1, 0, 0, "full_conflict");

    for (int r = 0; r < 3; r++) begin
      sh = int'($urandom_range(0, 31));
      nit_mem[r][PW-1:0] = PW'($urandom_range(0, 1023));
      for (int k = 0; k < 32; k++) set_nbr(r, k, int'($urandom_range(0, 31)) * 32 + (k + sh) % 32);
    end
    run_case(3, 0, 0, "multi_row");
    run_case(0, 0, 0, "zero_samples");
    run_case(3, 3, 0, "start_busy");

    for (int r = 0; r < 2; r++) begin
      nit_mem[r][PW-1:0] = PW'($urandom_range(0, 1023));
      for (int k = 0; k < 32; k++) set_nbr(r, k, (64 * k + 32 * r) % 1024);
    end
    run_case(2, 0, 10, "reset_mid");
    run_case(2, 0, 0, "after_reset");

    for (int t = 0; t < 6; t++) begin
      sh = int'($urandom_range(1, 4));
      fill_random(sh, t % 3);
      run_case(sh, 0, 0, $sformatf("rand%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
